// File: rtl/pri_mixer.sv
// Per-pixel priority mixer feeding the palette stage: picks bg0/bg1/fg/obj by programmable priority.
// Define PRI_MIXER_LINE_LATCH_EN to make the CPU registers shadows that are latched on each HBLANK.
module pri_mixer #(
    parameter int unsigned PIX_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce_pixel,
    input  logic [15:0]      MDin,
    output logic [15:0]      MDout,
    input  logic             CS,
    input  logic [2:0]       MA,
    input  logic             RWn,
    input  logic             UDSn,
    input  logic             LDSn,
    output logic             DTACKn,
    input  logic             HBLANKn_in,
    input  logic             VBLANKn_in,
    input  logic [PIX_W-1:0] bg0_pix,
    input  logic [PIX_W-1:0] bg1_pix,
    input  logic [PIX_W-1:0] fg_pix,
    input  logic [PIX_W-1:0] obj_pix,
    input  logic [1:0]       obj_pri,
    output logic [13:0]      IM,
    output logic             HBLANKn,
    output logic             VBLANKn
);

    // CPU-visible registers
    logic [11:0] reg0_q;
    logic [15:0] reg1_q;
    logic [7:0]  reg2_q;
    logic [13:0] reg3_q;
    logic        reg4_q;

    // Registers used by the pixel pipeline
    logic [11:0] act0;
    logic [15:0] act1;
    logic [7:0]  act2;
    logic [13:0] act3;
    logic        act4;

    logic [15:0] rd_word;
    logic [15:0] wr_word;
    logic        wr_en;
    logic [15:0] mdout_q;
    logic        dtack_n_q;

    always_comb begin
        rd_word = '0;
        case (MA)
            3'd0:    rd_word = {4'd0, reg0_q};
            3'd1:    rd_word = reg1_q;
            3'd2:    rd_word = {8'd0, reg2_q};
            3'd3:    rd_word = {2'd0, reg3_q};
            3'd4:    rd_word = {15'd0, reg4_q};
            default: rd_word = '0;
        endcase
    end

    // Merge only the strobed byte lanes into the current contents
    always_comb begin
        wr_en   = CS && !RWn;
        wr_word = {(UDSn ? rd_word[15:8] : MDin[15:8]), (LDSn ? rd_word[7:0] : MDin[7:0])};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg0_q    <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            reg3_q    <= '0;
            reg4_q    <= 1'b0;
            mdout_q   <= '0;
            dtack_n_q <= 1'b1;
        end else begin
            if (wr_en) begin
                case (MA)
                    3'd0:    reg0_q <= wr_word[11:0];
                    3'd1:    reg1_q <= wr_word;
                    3'd2:    reg2_q <= wr_word[7:0];
                    3'd3:    reg3_q <= wr_word[13:0];
                    3'd4:    reg4_q <= wr_word[0];
                    default: ;
                endcase
            end
            if (CS && RWn) mdout_q <= rd_word;
            dtack_n_q <= ~CS;
        end
    end

    assign MDout  = mdout_q;
    assign DTACKn = dtack_n_q;

`ifdef PRI_MIXER_LINE_LATCH_EN
    logic hb_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_prev_q <= 1'b0;
            act0      <= '0;
            act1      <= '0;
            act2      <= '0;
            act3      <= '0;
            act4      <= 1'b0;
        end else if (ce_pixel) begin
            hb_prev_q <= HBLANKn_in;
            if (hb_prev_q && !HBLANKn_in) begin
                act0 <= reg0_q;
                act1 <= reg1_q;
                act2 <= reg2_q;
                act3 <= reg3_q;
                act4 <= reg4_q;
            end
        end
    end
`else
    assign act0 = reg0_q;
    assign act1 = reg1_q;
    assign act2 = reg2_q;
    assign act3 = reg3_q;
    assign act4 = reg4_q;
`endif

    // Stage 1: effective priorities (transparent pen forces priority 0)
    logic [3:0]       obj_prog;
    logic [3:0]       bg0_eff, bg1_eff, fg_eff, obj_eff;
    logic [PIX_W-1:0] bg0_s1, bg1_s1, fg_s1, obj_s1;
    logic [3:0]       bg0_pri_s1, bg1_pri_s1, fg_pri_s1, obj_pri_s1;
    logic             hb_s1, vb_s1;

    always_comb begin
        obj_prog = act1[obj_pri*4 +: 4];
        bg0_eff  = (bg0_pix[3:0] == 4'd0) ? 4'd0 : act0[3:0];
        bg1_eff  = (bg1_pix[3:0] == 4'd0) ? 4'd0 : act0[7:4];
        fg_eff   = (fg_pix[3:0] == 4'd0) ? 4'd0 : act0[11:8];
        obj_eff  = (obj_pix[3:0] == 4'd0) ? 4'd0 : obj_prog;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bg0_s1     <= '0;
            bg1_s1     <= '0;
            fg_s1      <= '0;
            obj_s1     <= '0;
            bg0_pri_s1 <= '0;
            bg1_pri_s1 <= '0;
            fg_pri_s1  <= '0;
            obj_pri_s1 <= '0;
            hb_s1      <= 1'b0;
            vb_s1      <= 1'b0;
        end else if (ce_pixel) begin
            bg0_s1     <= bg0_pix;
            bg1_s1     <= bg1_pix;
            fg_s1      <= fg_pix;
            obj_s1     <= obj_pix;
            bg0_pri_s1 <= bg0_eff;
            bg1_pri_s1 <= bg1_eff;
            fg_pri_s1  <= fg_eff;
            obj_pri_s1 <= obj_eff;
            hb_s1      <= HBLANKn_in;
            vb_s1      <= VBLANKn_in;
        end
    end

    // Stage 2: later comparisons use >= so ties resolve fg > obj > bg1 > bg0
    logic [3:0]  win_pri;
    logic [13:0] win_pix;
    logic [13:0] im_d;
    logic [13:0] im_q;
    logic        hb_q, vb_q;

    always_comb begin
        win_pri = bg0_pri_s1;
        win_pix = {act2[1:0], bg0_s1[11:0]};
        if (bg1_pri_s1 >= win_pri) begin
            win_pri = bg1_pri_s1;
            win_pix = {act2[3:2], bg1_s1[11:0]};
        end
        if (obj_pri_s1 >= win_pri) begin
            win_pri = obj_pri_s1;
            win_pix = {act2[7:6], obj_s1[11:0]};
        end
        if (fg_pri_s1 >= win_pri) begin
            win_pri = fg_pri_s1;
            win_pix = {act2[5:4], fg_s1[11:0]};
        end
        im_d = (!act4 || win_pri == 4'd0) ? act3 : win_pix;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im_q <= '0;
            hb_q <= 1'b0;
            vb_q <= 1'b0;
        end else if (ce_pixel) begin
            im_q <= im_d;
            hb_q <= hb_s1;
            vb_q <= vb_s1;
        end
    end

    assign IM      = im_q;
    assign HBLANKn = hb_q;
    assign VBLANKn = vb_q;

endmodule

// File: tb/tb_pri_mixer.sv
// Directed bench for pri_mixer: priority, ties, transparency, latency, byte-lane CPU access.
// The line-latch section is compiled only when PRI_MIXER_LINE_LATCH_EN is defined.
module tb_pri_mixer;

    localparam int unsigned PIX_W = 12;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             ce_pixel;
    logic [15:0]      MDin;
    logic [15:0]      MDout;
    logic             CS;
    logic [2:0]       MA;
    logic             RWn;
    logic             UDSn;
    logic             LDSn;
    logic             DTACKn;
    logic             HBLANKn_in;
    logic             VBLANKn_in;
    logic [PIX_W-1:0] bg0_pix, bg1_pix, fg_pix, obj_pix;
    logic [1:0]       obj_pri;
    logic [13:0]      IM;
    logic             HBLANKn;
    logic             VBLANKn;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [15:0] rd;

    always #5 clk = ~clk;

    pri_mixer #(.PIX_W(PIX_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce_pixel   (ce_pixel),
        .MDin       (MDin),
        .MDout      (MDout),
        .CS         (CS),
        .MA         (MA),
        .RWn        (RWn),
        .UDSn       (UDSn),
        .LDSn       (LDSn),
        .DTACKn     (DTACKn),
        .HBLANKn_in (HBLANKn_in),
        .VBLANKn_in (VBLANKn_in),
        .bg0_pix    (bg0_pix),
        .bg1_pix    (bg1_pix),
        .fg_pix     (fg_pix),
        .obj_pix    (obj_pix),
        .obj_pri    (obj_pri),
        .IM         (IM),
        .HBLANKn    (HBLANKn),
        .VBLANKn    (VBLANKn)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        ce_pixel = 1'b1;
        cycle();
        ce_pixel = 1'b0;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [15:0] d,
                             input logic u, input logic l);
        MA = a; MDin = d; UDSn = u; LDSn = l; RWn = 1'b0; CS = 1'b1;
        cycle();
        CS = 1'b0; RWn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
        cycle();
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [15:0] d);
        MA = a; RWn = 1'b1; CS = 1'b1;
        cycle();
        d = MDout;
        CS = 1'b0;
        cycle();
    endtask

    // HBLANKn_in fall with ce: copies shadows when the line latch is built in
    task automatic latch_line();
        HBLANKn_in = 1'b1; tick();
        HBLANKn_in = 1'b0; tick();
        HBLANKn_in = 1'b1; tick();
    endtask

    task automatic set_pix(input logic [11:0] b0, input logic [11:0] b1,
                           input logic [11:0] f, input logic [11:0] o);
        bg0_pix = b0; bg1_pix = b1; fg_pix = f; obj_pix = o;
    endtask

    initial begin
        reset_n = 1'b0; ce_pixel = 1'b0; MDin = '0; CS = 1'b0; MA = '0; RWn = 1'b1;
        UDSn = 1'b1; LDSn = 1'b1; HBLANKn_in = 1'b0; VBLANKn_in = 1'b0; obj_pri = '0;
        set_pix(12'h000, 12'h000, 12'h000, 12'h000);
        repeat (3) cycle();
        reset_n = 1'b1;
        cycle();
        check_eq("rst_im", {2'b00, IM}, 16'h0000);
        check_eq("rst_hblank", {15'd0, HBLANKn}, 16'h0000);
        check_eq("rst_vblank", {15'd0, VBLANKn}, 16'h0000);
        check_eq("rst_dtack", {15'd0, DTACKn}, 16'h0001);
        check_eq("rst_mdout", MDout, 16'h0000);

        // bg0=1 bg1=2 fg=3; banks bg0=0 bg1=1 fg=2 obj=3
        reg_write(3'd0, 16'h0321, 1'b0, 1'b0);
        reg_write(3'd2, 16'h00E4, 1'b0, 1'b0);
        reg_write(3'd4, 16'h0001, 1'b0, 1'b0);
        VBLANKn_in = 1'b1;
        latch_line();
        set_pix(12'h011, 12'h022, 12'h033, 12'h000);
        HBLANKn_in = 1'b0;
        tick();
        check_eq("lat_1tick_im", {2'b00, IM}, 16'h0000);
        check_eq("lat_1tick_hb", {15'd0, HBLANKn}, 16'h0001);
        tick();
        check_eq("fg_wins", {2'b00, IM}, 16'h2033);
        check_eq("lat_2tick_hb", {15'd0, HBLANKn}, 16'h0000);
        check_eq("vblank_pass", {15'd0, VBLANKn}, 16'h0001);
        HBLANKn_in = 1'b1;
        fg_pix = 12'h030;
        tick(); tick();
        check_eq("fg_transp", {2'b00, IM}, 16'h1022);

        // Ties at priority 5: obj beats bg1 and bg0
        reg_write(3'd1, 16'h0050, 1'b0, 1'b0);
        reg_write(3'd0, 16'h0055, 1'b0, 1'b0);
        reg_write(3'd2, 16'h00C0, 1'b0, 1'b0);
        latch_line();
        obj_pri = 2'd1;
        set_pix(12'h011, 12'h0B1, 12'h030, 12'h0A5);
        tick(); tick();
        check_eq("tie_obj", {2'b00, IM}, 16'h30A5);
        obj_pri = 2'd0;
        tick(); tick();
        check_eq("tie_bg1", {2'b00, IM}, 16'h00B1);

        reg_write(3'd3, 16'h1ABC, 1'b0, 1'b0);
        latch_line();
        set_pix(12'h010, 12'h0B0, 12'h030, 12'h0A0);
        tick(); tick();
        check_eq("all_transp", {2'b00, IM}, 16'h1ABC);
        reg_write(3'd4, 16'h0000, 1'b0, 1'b0);
        latch_line();
        obj_pri = 2'd1;
        set_pix(12'h011, 12'h0B1, 12'h033, 12'h0A5);
        tick(); tick();
        check_eq("mix_off", {2'b00, IM}, 16'h1ABC);

        // Byte lanes
        reg_write(3'd3, 16'h0000, 1'b0, 1'b0);
        reg_read(3'd3, rd);
        check_eq("rd3_clear", rd, 16'h0000);
        reg_write(3'd3, 16'hFFFF, 1'b1, 1'b0);
        reg_read(3'd3, rd);
        check_eq("rd3_low_lane", rd, 16'h00FF);
        reg_write(3'd3, 16'hFFFF, 1'b0, 1'b1);
        reg_read(3'd3, rd);
        check_eq("rd3_high_lane", rd, 16'h3FFF);
        reg_write(3'd3, 16'h1234, 1'b1, 1'b1);
        reg_read(3'd3, rd);
        check_eq("rd3_no_strobe", rd, 16'h3FFF);
        reg_write(3'd6, 16'hFFFF, 1'b0, 1'b0);
        reg_read(3'd6, rd);
        check_eq("rd6_zero", rd, 16'h0000);
        reg_read(3'd0, rd);
        check_eq("rd0", rd, 16'h0055);
        reg_read(3'd1, rd);
        check_eq("rd1", rd, 16'h0050);
        reg_read(3'd2, rd);
        check_eq("rd2", rd, 16'h00C0);
        reg_read(3'd4, rd);
        check_eq("rd4", rd, 16'h0000);

        // DTACKn timing
        MA = 3'd0; RWn = 1'b1; CS = 1'b1;
        check_eq("dtack_cs_rise", {15'd0, DTACKn}, 16'h0001);
        cycle();
        check_eq("dtack_low_1", {15'd0, DTACKn}, 16'h0000);
        cycle();
        check_eq("dtack_low_2", {15'd0, DTACKn}, 16'h0000);
        CS = 1'b0;
        cycle();
        check_eq("dtack_release", {15'd0, DTACKn}, 16'h0001);

`ifdef PRI_MIXER_LINE_LATCH_EN
        reg_write(3'd4, 16'h0001, 1'b0, 1'b0);
        latch_line();
        set_pix(12'h010, 12'h0B0, 12'h030, 12'h0A0);
        tick(); tick();
        check_eq("ll_before", {2'b00, IM}, 16'h3FFF);
        reg_write(3'd3, 16'h0123, 1'b0, 1'b0);
        reg_read(3'd3, rd);
        check_eq("ll_shadow_rd", rd, 16'h0123);
        tick(); tick();
        check_eq("ll_held", {2'b00, IM}, 16'h3FFF);
        latch_line();
        tick(); tick();
        check_eq("ll_after", {2'b00, IM}, 16'h0123);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
